md5_work_dispatcher: RTL and testbench
======================================

// Module: md5_work_dispatcher
// PURPOSE
//   Issues candidate plaintexts from the candidate generator to the four MD5Controllers and
//   resolves the winning candidate. Counterpart to SuccessDetector: the detector reports which
//   controller matched, this block sends the work out and maps that index back to a candidate.
//   It sits between the candidate generator, the controller array and SuccessDetector.
// PARAMETERS
//   CAND_W   64  width of one candidate plaintext, in bits
//   CNT_W    32  width of tried_count
// PORTS
//   clk                  in   1         module clock, all logic on posedge
//   reset                in   1         asynchronous, active-high reset
//   enable               in   1         high = run search; low = abort/idle
//   cand_valid           in   1         generator has a candidate on cand_data
//   cand_data            in   CAND_W    candidate plaintext
//   cand_exhausted       in   1         generator has no further candidates (level)
//   cand_ready           out  1         dispatcher accepts cand_data this cycle
//   ctrl_start           out  4         1-cycle start pulse, bit i -> controller i
//   ctrl_candidate       out  4*CAND_W  candidate held for controller i, bits [i*CAND_W +: CAND_W]
//   ctrl_done            in   4         1-cycle pulse: controller i finished a hash
//   success              in   1         SuccessDetector success
//   successfulController in   2         SuccessDetector winning index
//   found                out  1         sticky: match found
//   found_index          out  2         controller that matched
//   found_candidate      out  CAND_W    plaintext that matched
//   search_done          out  1         sticky: search finished (found or exhausted)
//   tried_count          out  CNT_W     candidates dispatched, saturating
// BEHAVIOUR
//   Reset: state=IDLE; busy[3:0]=0; every output 0.
//   States: IDLE, DISPATCH, DRAIN, FOUND, EXHAUSTED.
//   - IDLE: enable=1 -> DISPATCH; tried_count cleared on that transition.
//   - DISPATCH: cand_exhausted=1 -> DRAIN; success=1 -> FOUND.
//   - DRAIN: success=1 -> FOUND; else busy==0 -> EXHAUSTED.
//   - FOUND, EXHAUSTED: terminal, search_done=1; FOUND also drives found=1.
//   - Any state: enable=0 -> IDLE next cycle. This clears busy, found and search_done.
//     tried_count, found_index and found_candidate hold.
//   Precedence when several apply in one cycle: enable=0 > success > cand_exhausted.
//   Handshake:
//   - cand_ready = (state==DISPATCH) & ~cand_exhausted & ~success & (busy != 4'b1111).
//   - Accept = cand_valid & cand_ready. At most one accept per cycle.
//   - The target is the lowest-index controller with busy=0.
//   - On accept, edge N: ctrl_candidate[i]<=cand_data; busy[i]<=1; tried_count+=1 (saturates).
//   - ctrl_start[i] is high for exactly cycle N+1.
//   - ctrl_candidate[i] changes only on an accept to controller i.
//   Busy release: ctrl_done[i] at edge M clears busy[i] at edge M+1.
//   - Controller i is re-eligible at the earliest from cycle M+2.
//   - This covers SuccessDetector's 1-cycle latency, so the winning candidate is never overwritten.
//   - ctrl_done[i] while busy[i]=0 is ignored.
//   Success capture: applies when success=1 in DISPATCH or DRAIN.
//   - found_index<=successfulController; found_candidate<=ctrl_candidate[successfulController].
//   - The capture happens on the same edge as the transition to FOUND.
//   - success in IDLE, FOUND or EXHAUSTED is ignored; the first capture is never overwritten.
//   Simultaneous events: ctrl_done[i] and an accept for controller i in the same cycle cannot
//   occur, because eligibility uses registered busy.
//   Reset asserted mid-search: all outputs go to 0 immediately (asynchronous).
// TESTING
//   T1 Fill: enable=1, cand_valid=1, data 0x..01..0x..04 over 4 cycles
//      -> ctrl_start pulses 0001,0010,0100,1000 on consecutive cycles; cand_ready=0 once all busy;
//      tried_count=4.
//   T2 Reuse: ctrl_done=0010 at cycle M
//      -> busy[1] clears at M+1; next candidate goes to ctrl 1 at M+2 (not M+1);
//      ctrl_start=0010 at M+3.
//   T3 Found: ctrl 2 holds 0x..03; success=1, successfulController=2
//      -> found=1, found_index=2, found_candidate=0x..03, search_done=1, cand_ready=0.
//      A later success with index 0 leaves all of these unchanged.
//   T4 Exhaust: after 6 accepts raise cand_exhausted, then deliver done to all busy controllers
//      -> stays DRAIN until the last busy bit clears; then search_done=1, found=0, tried_count=6.
//   T5 Abort/reset: enable=0 mid-DISPATCH -> next cycle cand_ready=0, busy=0, tried_count held;
//      async reset mid-DRAIN -> all outputs 0 before the next clk edge.
//   T6 Saturation: CNT_W=4, 20 accepts -> tried_count stops at 4'hF.

Source files
------------

// File: rtl/md5_work_dispatcher.sv
// md5_work_dispatcher: hands candidate plaintexts to four MD5 controllers,
// tracks which controllers are busy, and maps SuccessDetector's winning index
// back to the candidate that produced the match.
module md5_work_dispatcher #(
    parameter int unsigned CAND_W = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                cand_valid,
    input  logic [CAND_W-1:0]   cand_data,
    input  logic                cand_exhausted,
    output logic                cand_ready,
    output logic [3:0]          ctrl_start,
    output logic [4*CAND_W-1:0] ctrl_candidate,
    input  logic [3:0]          ctrl_done,
    input  logic                success,
    input  logic [1:0]          successfulController,
    output logic                found,
    output logic [1:0]          found_index,
    output logic [CAND_W-1:0]   found_candidate,
    output logic                search_done,
    output logic [CNT_W-1:0]    tried_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISPATCH,
        S_DRAIN,
        S_FOUND,
        S_EXHAUSTED
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                   state_q, state_d;
    logic [3:0]               busy_q, busy_d;
    logic [3:0]               release_q, release_d;
    logic [3:0]               start_q, start_d;
    logic [3:0][CAND_W-1:0]   cand_q, cand_d;
    logic [CNT_W-1:0]         tried_q, tried_d;
    logic                     found_q, found_d;
    logic                     search_done_q, search_done_d;
    logic [1:0]               found_index_q, found_index_d;
    logic [CAND_W-1:0]        found_cand_q, found_cand_d;

    logic                     accept;
    logic [1:0]               target;
    logic                     any_free;

    assign cand_ready = (state_q == S_DISPATCH) & ~cand_exhausted & ~success & (busy_q != 4'b1111);
    // An abort cycle takes nothing, so the count and held candidates stay put.
    assign accept     = cand_valid & cand_ready & enable;

    assign ctrl_start      = start_q;
    assign ctrl_candidate  = cand_q;
    assign found           = found_q;
    assign found_index     = found_index_q;
    assign found_candidate = found_cand_q;
    assign search_done     = search_done_q;
    assign tried_count     = tried_q;

    // Pick the lowest-index controller whose registered busy bit is clear.
    always_comb begin
        target   = '0;
        any_free = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!busy_q[i] && !any_free) begin
                target   = 2'(i);
                any_free = 1'b1;
            end
        end
    end

    // Next-state: search sequencing, dispatch bookkeeping and match capture.
    // ctrl_done is first registered into release_q, so busy drops one edge
    // later; that extra cycle keeps the winner's candidate intact while
    // SuccessDetector resolves.
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q & ~release_q;
        release_d     = ctrl_done & busy_q;
        start_d       = '0;
        cand_d        = cand_q;
        tried_d       = tried_q;
        found_d       = found_q;
        search_done_d = search_done_q;
        found_index_d = found_index_q;
        found_cand_d  = found_cand_q;

        if (!enable) begin
            state_d       = S_IDLE;
            busy_d        = '0;
            release_d     = '0;
            found_d       = 1'b0;
            search_done_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_DISPATCH;
                    tried_d = '0;
                end
                S_DISPATCH, S_DRAIN: begin
                    if (success) begin
                        state_d       = S_FOUND;
                        found_d       = 1'b1;
                        search_done_d = 1'b1;
                        found_index_d = successfulController;
                        found_cand_d  = cand_q[successfulController];
                    end else if (state_q == S_DISPATCH) begin
                        if (cand_exhausted) begin
                            state_d = S_DRAIN;
                        end
                    end else if (busy_q == '0) begin
                        state_d       = S_EXHAUSTED;
                        search_done_d = 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase

            if (accept) begin
                cand_d[target]  = cand_data;
                busy_d[target]  = 1'b1;
                start_d[target] = 1'b1;
                if (tried_q != '1) begin
                    tried_d = tried_q + CNT_ONE;
                end
            end
        end
    end

    // State and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            busy_q        <= '0;
            release_q     <= '0;
            start_q       <= '0;
            cand_q        <= '0;
            tried_q       <= '0;
            found_q       <= 1'b0;
            search_done_q <= 1'b0;
            found_index_q <= '0;
            found_cand_q  <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            release_q     <= release_d;
            start_q       <= start_d;
            cand_q        <= cand_d;
            tried_q       <= tried_d;
            found_q       <= found_d;
            search_done_q <= search_done_d;
            found_index_q <= found_index_d;
            found_cand_q  <= found_cand_d;
        end
    end

endmodule

// File: tb/tb_md5_work_dispatcher.sv
// Bench for md5_work_dispatcher: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_md5_work_dispatcher;

    localparam int unsigned CAND_W = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic                cand_valid;
    logic [CAND_W-1:0]   cand_data;
    logic                cand_exhausted;
    logic [3:0]          ctrl_done;
    logic                success;
    logic [1:0]          succ_idx;

    logic                cand_ready;
    logic [3:0]          ctrl_start;
    logic [4*CAND_W-1:0] ctrl_candidate;
    logic                found;
    logic [1:0]          found_index;
    logic [CAND_W-1:0]   found_candidate;
    logic                search_done;
    logic [31:0]         tried_count;

    logic                s_ready;
    logic [3:0]          s_start;
    logic [4*CAND_W-1:0] s_cand;
    logic                s_found;
    logic [1:0]          s_fidx;
    logic [CAND_W-1:0]   s_fcand;
    logic                s_sdone;
    logic [3:0]          s_tried;

    md5_work_dispatcher dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cand_valid(cand_valid), .cand_data(cand_data), .cand_exhausted(cand_exhausted),
        .cand_ready(cand_ready), .ctrl_start(ctrl_start), .ctrl_candidate(ctrl_candidate),
        .ctrl_done(ctrl_done), .success(success), .successfulController(succ_idx),
        .found(found), .found_index(found_index), .found_candidate(found_candidate),
        .search_done(search_done), .tried_count(tried_count)
    );

    md5_work_dispatcher #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .enable(enable),
        .cand_valid(cand_valid), .cand_data(cand_data), .cand_exhausted(cand_exhausted),
        .cand_ready(s_ready), .ctrl_start(s_start), .ctrl_candidate(s_cand),
        .ctrl_done(ctrl_done), .success(success), .successfulController(succ_idx),
        .found(s_found), .found_index(s_fidx), .found_candidate(s_fcand),
        .search_done(s_sdone), .tried_count(s_tried)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 dispatching, 2 draining, 3 found, 4 exhausted.
    int                m_phase;
    bit [3:0]          m_busy;
    int                m_clr [4];
    logic [CAND_W-1:0] m_cand [4];
    logic [63:0]       m_tried;
    bit [3:0]          m_start;
    bit [1:0]          m_fidx;
    logic [CAND_W-1:0] m_fcand;
    int                cyc = 0;

    task automatic model_reset();
        m_phase = 0;
        m_busy  = '0;
        for (int i = 0; i < 4; i++) begin
            m_clr[i]  = -1;
            m_cand[i] = '0;
        end
        m_tried = '0;
        m_start = '0;
        m_fidx  = '0;
        m_fcand = '0;
    endtask

    function automatic bit m_ready();
        return (m_phase == 1) && !cand_exhausted && !success && (m_busy != 4'hF);
    endfunction

    function automatic bit [3:0] done_all();
        bit [3:0] d;
        for (int i = 0; i < 4; i++) d[i] = m_busy[i] && (m_clr[i] < 0);
        return d;
    endfunction

    task automatic model_edge();
        bit       acc;
        int       tgt;
        bit [3:0] busy_pre;
        acc      = m_ready() && cand_valid && enable;
        busy_pre = m_busy;
        tgt      = -1;
        for (int i = 0; i < 4; i++) if (!m_busy[i] && tgt < 0) tgt = i;
        m_start = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_clr[i] == cyc) begin
                m_busy[i] = 1'b0;
                m_clr[i]  = -1;
            end
            if (ctrl_done[i] && busy_pre[i]) m_clr[i] = cyc + 1;
        end
        if (!enable) begin
            m_phase = 0;
            m_busy  = '0;
            for (int i = 0; i < 4; i++) m_clr[i] = -1;
        end else if (m_phase == 0) begin
            m_phase = 1;
            m_tried = '0;
        end else if (m_phase == 1 || m_phase == 2) begin
            if (success) begin
                m_fidx  = succ_idx;
                m_fcand = m_cand[succ_idx];
                m_phase = 3;
            end else if (m_phase == 1 && cand_exhausted) begin
                m_phase = 2;
            end else if (m_phase == 2 && busy_pre == 4'h0) begin
                m_phase = 4;
            end
        end
        if (acc) begin
            m_cand[tgt]  = cand_data;
            m_busy[tgt]  = 1'b1;
            m_start[tgt] = 1'b1;
            m_tried      = m_tried + 64'd1;
        end
        cyc++;
    endtask

    task automatic check_outputs();
        logic [4*CAND_W-1:0] ecand;
        logic [31:0]         e32;
        logic [3:0]          e4;
        ecand = {m_cand[3], m_cand[2], m_cand[1], m_cand[0]};
        e32   = (m_tried > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_tried[31:0];
        e4    = (m_tried > 64'd15) ? 4'hF : m_tried[3:0];
        chk("ctrl_start", ctrl_start, m_start);
        chk("ctrl_candidate", ctrl_candidate, ecand);
        chk("found", found, m_phase == 3);
        chk("search_done", search_done, m_phase >= 3);
        chk("found_index", found_index, m_fidx);
        chk("found_candidate", found_candidate, m_fcand);
        chk("tried_count", tried_count, e32);
        chk("tried_count_w4", s_tried, e4);
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1;
        chk("cand_ready", cand_ready, m_ready());
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; cand_valid = 1'b0; cand_data = '0;
        cand_exhausted = 1'b0; ctrl_done = '0; success = 1'b0; succ_idx = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_ready", cand_ready, 1'b0);
        check_outputs();
        reset = 1'b0;

        // T1 fill all four controllers
        enable = 1'b1;
        step();
        cand_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cand_data = 64'(k);
            step();
            chk("t1_start", ctrl_start, 4'b0001 << (k - 1));
        end
        step();
        chk("t1_ready_full", cand_ready, 1'b0);
        chk("t1_tried", tried_count, 32'd4);

        // T2 reuse controller 1 only two edges after its done pulse
        cand_valid = 1'b0; ctrl_done = 4'b0010;
        step();
        ctrl_done = '0; cand_valid = 1'b1; cand_data = 64'd5;
        step();
        chk("t2_ready_after_release", cand_ready, 1'b1);
        step();
        chk("t2_start", ctrl_start, 4'b0010);
        chk("t2_cand1", ctrl_candidate[CAND_W +: CAND_W], 64'd5);

        // T3 match on controller 2, later success ignored
        cand_valid = 1'b0; success = 1'b1; succ_idx = 2'd2;
        step();
        success = 1'b0;
        chk("t3_found", found, 1'b1);
        chk("t3_index", found_index, 2'd2);
        chk("t3_cand", found_candidate, 64'd3);
        chk("t3_done", search_done, 1'b1);
        chk("t3_ready", cand_ready, 1'b0);
        success = 1'b1; succ_idx = 2'd0;
        step();
        success = 1'b0;
        chk("t3_index_kept", found_index, 2'd2);
        chk("t3_cand_kept", found_candidate, 64'd3);
        enable = 1'b0;
        step();
        chk("t3_abort_found", found, 1'b0);
        chk("t3_abort_tried", tried_count, 32'd5);

        // T4 six accepts, exhaust, drain
        enable = 1'b1;
        step();
        chk("t4_tried_clear", tried_count, 32'd0);
        cand_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cand_data = 64'h11 + 64'(k);
            step();
        end
        cand_valid = 1'b0; ctrl_done = 4'b0011;
        step();
        ctrl_done = '0; cand_valid = 1'b1; cand_data = 64'h15;
        step();
        step();
        cand_data = 64'h16;
        step();
        cand_valid = 1'b0; cand_exhausted = 1'b1;
        step();
        chk("t4_ready_drain", cand_ready, 1'b0);
        for (int k = 0; k < 4; k++) begin
            ctrl_done = 4'b0001 << k;
            step();
        end
        ctrl_done = '0;
        step();
        chk("t4_still_drain", search_done, 1'b0);
        step();
        chk("t4_done", search_done, 1'b1);
        chk("t4_found", found, 1'b0);
        chk("t4_tried", tried_count, 32'd6);

        // T5 abort mid-dispatch, then async reset mid-drain
        enable = 1'b0; cand_exhausted = 1'b0;
        step();
        enable = 1'b1;
        step();
        cand_valid = 1'b1;
        step();
        step();
        enable = 1'b0;
        step();
        chk("t5_ready", cand_ready, 1'b0);
        chk("t5_tried_hold", tried_count, 32'd2);
        enable = 1'b1; cand_valid = 1'b0;
        step();
        cand_valid = 1'b1; cand_data = 64'h21;
        step();
        chk("t5_busy_cleared", ctrl_start, 4'b0001);
        cand_valid = 1'b0; cand_exhausted = 1'b1;
        step();
        reset = 1'b1;
        #1;
        model_reset();
        chk("t5_reset_ready", cand_ready, 1'b0);
        check_outputs();
        enable = 1'b0; cand_exhausted = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // T6 saturation of the narrow counter
        enable = 1'b1;
        step();
        for (int k = 0; k < 200 && m_tried < 64'd20; k++) begin
            cand_valid = 1'b1;
            cand_data  = {$urandom, $urandom};
            ctrl_done  = done_all();
            step();
        end
        cand_valid = 1'b0; ctrl_done = '0;
        chk("t6_sat", s_tried, 4'hF);
        chk("t6_wide", tried_count, 32'd20);
        enable = 1'b0;
        step();

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            if (!enable) enable = 1'b1;
            else enable = ($urandom_range(199) != 0) && !(m_phase >= 3 && $urandom_range(7) == 0);
            cand_valid = ($urandom_range(9) < 7);
            cand_data  = {$urandom, $urandom};
            if (m_phase == 0) cand_exhausted = 1'b0;
            else if ($urandom_range(99) == 0) cand_exhausted = 1'b1;
            success  = ($urandom_range(79) == 0);
            succ_idx = 2'($urandom_range(3));
            for (int i = 0; i < 4; i++) begin
                if (m_busy[i]) ctrl_done[i] = (m_clr[i] < 0) && ($urandom_range(3) == 0);
                else ctrl_done[i] = ($urandom_range(19) == 0);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
